// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   state_e     : scanner FSM states (scan, debounce, pressed)
//   tick_div()  : divider terminal count for a tick generator (Fclk / F)
//   cnt_width() : bits needed to hold a counter value in 0..max_val
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StPressed  = 2'd2
  } state_e;

  function automatic int unsigned tick_div(int unsigned fclk, int unsigned f);
    return fclk / f;
  endfunction

  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Periodic clock-enable generator. The counter runs 1..Fclk/F and ce is high on the
// cycle it holds the terminal count, so the period is exactly Fclk/F cycles.
// Reusable for the display's 1 ms and 100 ms enables.
//   clk : system clock
//   rst : synchronous reset, active-high (counter cleared to 0)
//   ce  : one-cycle enable pulse
module tick_gen
  import keypad_pkg::*;
#(
  parameter int unsigned Fclk = 50000000,
  parameter int unsigned F    = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic ce
);

  localparam int unsigned Tc   = tick_div(Fclk, F);
  localparam int unsigned CntW = cnt_width(Tc);
  localparam logic [CntW-1:0] TcV = CntW'(Tc);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    ce    = (cnt_q == TcV);
    cnt_d = ce ? CntW'(1) : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex matrix-keypad scanner. Drives one row low per scan tick, reads the
// active-low columns through a 2-flop synchronizer, debounces presses and releases,
// and shifts each accepted key code into a 16-bit word for the 7-segment display.
//   clk       : system clock
//   rst       : synchronous reset, active-high
//   col_n     : keypad columns, asynchronous, low = contact
//   row_n     : keypad rows, one-hot active-low
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle pulse per accepted key
//   key_held  : high while the accepted key is still down
//   dat       : entered digits, newest in [3:0]
//   ce_scan   : one-cycle scan tick
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key after
// REP_DELAY ticks and then every REP_RATE ticks.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned Fclk      = 50000000,
  parameter int unsigned Fscan     = 1000,
  parameter int unsigned DEB_TICKS = 20,
  parameter int unsigned REP_DELAY = 500,
  parameter int unsigned REP_RATE  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] dat,
  output logic        ce_scan
);

  // Debounce count may step one past DEB_TICKS when DEB_TICKS is 1.
  localparam int unsigned DebW = cnt_width(DEB_TICKS + 1);
  localparam logic [DebW-1:0] DebV = DebW'(DEB_TICKS);

  logic [3:0]      col_meta_q, col_s_q;
  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      cand_q, cand_d;
  logic [DebW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      key_code_q, key_code_d;
  logic [15:0]     dat_q, dat_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            any_low;
  logic [1:0]      low_col;
  logic            cand_low;
  logic            emit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned HoldW  = cnt_width(RepMax);

  logic [HoldW-1:0] hold_q, hold_d, hold_inc;
  logic             rep_q, rep_d;  // set once the initial delay has elapsed
`endif

  tick_gen #(
    .Fclk (Fclk),
    .F    (Fscan)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .ce  (ce_scan)
  );

  // Lowest-index low column wins.
  always_comb begin
    any_low = 1'b0;
    low_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) begin
        any_low = 1'b1;
        low_col = 2'(i);
      end
    end
  end

  assign cand_low = ~col_s_q[cand_q[1:0]];
  assign cnt_inc  = cnt_q + DebW'(1);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    dat_d      = dat_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    emit       = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_d     = hold_q;
    rep_d      = rep_q;
    hold_inc   = hold_q + HoldW'(1);
`endif
    if (ce_scan) begin
      unique case (state_q)
        StScan: begin
          if (any_low) begin
            cand_d  = {row_q, low_col};
            cnt_d   = DebW'(1);
            state_d = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        StDebounce: begin
          if (any_low && (low_col == cand_q[1:0])) begin
            if (cnt_inc >= DebV) begin
              emit    = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;  // reused as the release count
              state_d = StPressed;
`ifdef KEYPAD_AUTOREPEAT_EN
              hold_d  = '0;
              rep_d   = 1'b0;
`endif
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = StScan;
          end
        end
        StPressed: begin
          if (cand_low) begin
            cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if ((!rep_q && (hold_inc == HoldW'(REP_DELAY))) ||
                (rep_q && (hold_inc == HoldW'(REP_RATE)))) begin
              emit   = 1'b1;
              hold_d = '0;
              rep_d  = 1'b1;
            end else begin
              hold_d = hold_inc;
            end
`endif
          end else if (cnt_inc >= DebV) begin
            cnt_d   = '0;
            held_d  = 1'b0;
            row_d   = row_q + 2'd1;
            state_d = StScan;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StScan;
        end
      endcase
    end
    if (emit) begin
      valid_d    = 1'b1;
      key_code_d = cand_q;
      dat_d      = {dat_q[11:0], cand_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      state_q    <= StScan;
      row_q      <= 2'd0;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      key_code_q <= 4'd0;
      dat_q      <= 16'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      col_meta_q <= col_n;
      col_s_q    <= col_meta_q;
      state_q    <= state_d;
      row_q      <= row_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      dat_q      <= dat_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign row_n     = ~(4'b0001 << row_q);
  assign key_code  = key_code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign dat       = dat_q;

endmodule
